exec_pipe: RTL and testbench
============================

# exec_pipe

Parametrised, registered execute stage for the out-of-order core. It replaces the purely combinational execute block.
- Lane counts and data/tag/immediate/address widths are generic.
- Every functional unit gets a valid/ready handshake with output backpressure.
- The multiplier becomes a MUL_LAT-deep stallable pipeline.
- Immediates are selectable as zero- or sign-extended.

It sits between the reservation-station issue logic and the CDB/writeback arbiter and memory interface.

## Interface
Parameters:
- DATA_W, 16: operand/result width
- TAG_W, 5: destination tag width
- IMM_W, 5: immediate width
- NUM_ALU, 2: number of ALU lanes (1..4)
- MUL_LAT, 3: multiplier pipeline depth in cycles (1..4)
- ADDR_HI_W, 9: upper address bits taken from LS src2; address width = DATA_W+ADDR_HI_W
- LS_DATA_W, 8: store data width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid_i / alu_ready_o  in/out  NUM_ALU  per-lane issue handshake
- alu_src1_i, alu_src2_i  in  NUM_ALU×DATA_W  operands
- alu_imm_i  in  NUM_ALU×IMM_W  immediate
- alu_imm_sel_i, alu_imm_sext_i  in  NUM_ALU  1 = use imm; 1 = sign-extend imm
- alu_op_i  in  NUM_ALU×4  existing ALU op encoding
- alu_tag_i  in  NUM_ALU×TAG_W  destination tag
- alu_valid_o / alu_ready_i  out/in  NUM_ALU  result handshake
- alu_res_o  out  NUM_ALU×DATA_W  result
- alu_tag_o  out  NUM_ALU×TAG_W  result tag
- mul_valid_i, mul_ready_o, mul_src1_i, mul_src2_i, mul_imm_i, mul_imm_sel_i, mul_imm_sext_i, mul_tag_i: as ALU, single lane
- mul_valid_o, mul_ready_i, mul_res_o (DATA_W, low half of product), mul_tag_o
- ls_valid_i / ls_ready_o  in/out  1
- ls_src1_i, ls_src2_i, ls_src3_i  in  DATA_W  addr low / addr high / store data
- ls_write_i  in  1  1 = store
- ls_tag_i  in  TAG_W
- ls_valid_o / ls_ready_i  out/in  1  memory request handshake
- ls_addr_o  out  DATA_W+ADDR_HI_W  {src2[ADDR_HI_W-1:0], src1}
- ls_data_o  out  LS_DATA_W  src3[LS_DATA_W-1:0]
- ls_r_nw_o  out  1  ~write
- ls_tag_o  out  TAG_W

## Operation
- Second operand is imm (zero- or sign-extended to DATA_W per *_imm_sext_i) when imm_sel=1, else src2. The same mux is used on ALU and MUL lanes.
- ALU lane: ALU result plus tag captured into a one-entry output register on accepted issue (valid_i & ready_o).
- MUL lane: MUL_LAT-stage pipeline.
  - Stage 0 captures operands.
  - Result appears at the final stage register.
  - Valid and tag travel with the data.
  - Product truncated to low DATA_W bits.
- LS lane: one-entry request register; address/data/r_nw/tag captured on accept.
- Per-lane ready: ready_o = ~valid_o | ready_i for ALU and LS. For MUL, the whole pipe advances when ~mul_valid_o | mul_ready_i; mul_ready_o equals that advance condition. Bubbles inside the MUL pipe are not squeezed out.
- Output register holds data and tag stable while valid_o & ~ready_i.
- Lanes are fully independent; no ordering between lanes.

## Timing
- Reset (async on rst_n low): all valid_o = 0, all data/tag/addr outputs = 0, ls_r_nw_o = 1. All ready_o = 1 one cycle after reset release.
- ALU and LS latency 1: issue accepted at edge N gives valid_o high after edge N.
- MUL latency MUL_LAT with no stall.
- Full throughput: one accepted op per lane per cycle while ready_i is held 1.
- Simultaneous output accept and new input in the same cycle: the register reloads, valid stays 1, and no bubble is inserted.
- MUL stall: all stages freeze, including bubbles; resumes on the cycle ready_i returns.
- valid_i while ready_o = 0: not accepted; the upstream must hold its inputs.
- Reset mid-operation: all in-flight ops are discarded with no output pulse.

## Structure
- exec_pkg: width defaults, ALU op enum, ls request struct {addr, data, r_nw, tag}, and an imm-extend function.
- Sub-module exec_mul_pipe: parametrised MUL_LAT stages with valid/tag shift and a common stall enable.
- Existing ALU and MUL combinational units are instantiated inside, one ALU per lane via generate.

## Test plan
- ALU0 add src1=0x0005, imm=5'h1F, sext=1 -> alu_res_o[0]=0x0004 one cycle later, tag echoed. With sext=0 -> 0x0024.
- MUL_LAT=3, back-to-back issues 3×4, 7×9, 0xFFFF×2 with ready_i=1 -> results 0x000C, 0x003F, 0xFFFE on cycles 3, 4, 5, tags in order.
- MUL stall: hold mul_ready_i=0 while valid_o -> mul_ready_o=0, pipe frozen. Release -> results emerge in order with none lost or duplicated.
- LS store src1=0xBEEF, src2=0x01A5, src3=0x1234 -> ls_addr_o=0x1A5BEEF, ls_data_o=0x34, ls_r_nw_o=0. Held stable for 3 cycles with ls_ready_i=0.
- ALU1 output held by alu_ready_i=0 -> alu_ready_o[1]=0 and the new issue is not accepted. The ALU0 lane continues unaffected.
- Assert rst_n low with all lanes holding valid -> all valid_o drop immediately, outputs = 0, ls_r_nw_o=1.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: default widths, ALU op codes,
// the memory request layout and the immediate extender used by ALU and MUL lanes.
package exec_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int TAG_W_DEF     = 5;
   localparam int IMM_W_DEF     = 5;
   localparam int ADDR_HI_W_DEF = 9;
   localparam int LS_DATA_W_DEF = 8;
   localparam int EXT_W         = 64;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   typedef struct packed {
      logic [DATA_W_DEF+ADDR_HI_W_DEF-1:0] addr;
      logic [LS_DATA_W_DEF-1:0]            data;
      logic                                r_nw;
      logic [TAG_W_DEF-1:0]                tag;
   } ls_req_t;

   // Bits above immW are filled with the immediate's top bit when sext is set, else zero.
   function automatic logic [EXT_W-1:0] extendImm(input logic [EXT_W-1:0] imm,
                                                  input int immW,
                                                  input logic sext);
      logic [EXT_W-1:0] ext;
      logic             fill;
      fill = sext & imm[immW-1];
      for (int b = 0; b < EXT_W; b++) begin
         ext[b] = (b < immW) ? imm[b] : fill;
      end
      return ext;
   endfunction

endpackage

// File: rtl/exec_mul_pipe.sv
// Stallable multiplier pipeline: the truncated product enters stage 0 and valid/tag ride
// alongside it; all stages, bubbles included, freeze together while the output is blocked.
module exec_mul_pipe
   import exec_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TAG_W   = TAG_W_DEF,
   parameter int MUL_LAT = 3
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [TAG_W-1:0]  tag_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] res_o,
   output logic [TAG_W-1:0]  tag_o
);

   logic              w_advance;
   logic [DATA_W-1:0] w_prod;
   logic              r_valid [MUL_LAT];
   logic [DATA_W-1:0] r_res   [MUL_LAT];
   logic [TAG_W-1:0]  r_tag   [MUL_LAT];

   assign w_prod    = a_i * b_i;
   assign w_advance = ~r_valid[MUL_LAT-1] | ready_i;
   assign ready_o   = w_advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < MUL_LAT; s++) begin
            r_valid[s] <= 1'b0;
            r_res[s]   <= '0;
            r_tag[s]   <= '0;
         end
      end else if (w_advance) begin
         r_valid[0] <= valid_i;
         r_res[0]   <= w_prod;
         r_tag[0]   <= tag_i;
         for (int s = 1; s < MUL_LAT; s++) begin
            r_valid[s] <= r_valid[s-1];
            r_res[s]   <= r_res[s-1];
            r_tag[s]   <= r_tag[s-1];
         end
      end
   end

   assign valid_o = r_valid[MUL_LAT-1];
   assign res_o   = r_res[MUL_LAT-1];
   assign tag_o   = r_tag[MUL_LAT-1];

endmodule

// File: rtl/exec_pipe.sv
// Registered execute stage: NUM_ALU single-entry ALU lanes, a stallable multiplier lane
// and a single-entry load/store request register, each with its own valid/ready handshake.
module exec_pipe
   import exec_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int TAG_W     = TAG_W_DEF,
   parameter int IMM_W     = IMM_W_DEF,
   parameter int NUM_ALU   = 2,
   parameter int MUL_LAT   = 3,
   parameter int ADDR_HI_W = ADDR_HI_W_DEF,
   parameter int LS_DATA_W = LS_DATA_W_DEF
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_ALU-1:0]          alu_valid_i,
   output logic [NUM_ALU-1:0]          alu_ready_o,
   input  logic [NUM_ALU*DATA_W-1:0]   alu_src1_i,
   input  logic [NUM_ALU*DATA_W-1:0]   alu_src2_i,
   input  logic [NUM_ALU*IMM_W-1:0]    alu_imm_i,
   input  logic [NUM_ALU-1:0]          alu_imm_sel_i,
   input  logic [NUM_ALU-1:0]          alu_imm_sext_i,
   input  logic [NUM_ALU*4-1:0]        alu_op_i,
   input  logic [NUM_ALU*TAG_W-1:0]    alu_tag_i,
   output logic [NUM_ALU-1:0]          alu_valid_o,
   input  logic [NUM_ALU-1:0]          alu_ready_i,
   output logic [NUM_ALU*DATA_W-1:0]   alu_res_o,
   output logic [NUM_ALU*TAG_W-1:0]    alu_tag_o,
   input  logic                        mul_valid_i,
   output logic                        mul_ready_o,
   input  logic [DATA_W-1:0]           mul_src1_i,
   input  logic [DATA_W-1:0]           mul_src2_i,
   input  logic [IMM_W-1:0]            mul_imm_i,
   input  logic                        mul_imm_sel_i,
   input  logic                        mul_imm_sext_i,
   input  logic [TAG_W-1:0]            mul_tag_i,
   output logic                        mul_valid_o,
   input  logic                        mul_ready_i,
   output logic [DATA_W-1:0]           mul_res_o,
   output logic [TAG_W-1:0]            mul_tag_o,
   input  logic                        ls_valid_i,
   output logic                        ls_ready_o,
   input  logic [DATA_W-1:0]           ls_src1_i,
   input  logic [DATA_W-1:0]           ls_src2_i,
   input  logic [DATA_W-1:0]           ls_src3_i,
   input  logic                        ls_write_i,
   input  logic [TAG_W-1:0]            ls_tag_i,
   output logic                        ls_valid_o,
   input  logic                        ls_ready_i,
   output logic [DATA_W+ADDR_HI_W-1:0] ls_addr_o,
   output logic [LS_DATA_W-1:0]        ls_data_o,
   output logic                        ls_r_nw_o,
   output logic [TAG_W-1:0]            ls_tag_o
);

   localparam int SHAMT_W = $clog2(DATA_W);
   localparam int ADDR_W  = DATA_W + ADDR_HI_W;

   // Same layout as exec_pkg::ls_req_t, sized by this instance's parameters.
   typedef struct packed {
      logic [ADDR_W-1:0]    addr;
      logic [LS_DATA_W-1:0] data;
      logic                 r_nw;
      logic [TAG_W-1:0]     tag;
   } lsReq_t;

   for (genvar g = 0; g < NUM_ALU; g++) begin : gAlu
      logic [DATA_W-1:0] w_a;
      logic [DATA_W-1:0] w_b;
      logic [DATA_W-1:0] w_res;
      logic              w_accept;
      logic              r_valid;
      logic [DATA_W-1:0] r_res;
      logic [TAG_W-1:0]  r_tag;

      assign w_a = alu_src1_i[g*DATA_W +: DATA_W];
      assign w_b = alu_imm_sel_i[g]
                 ? DATA_W'(extendImm(EXT_W'(alu_imm_i[g*IMM_W +: IMM_W]), IMM_W, alu_imm_sext_i[g]))
                 : alu_src2_i[g*DATA_W +: DATA_W];

      always_comb begin
         w_res = '0;
         case (alu_op_e'(alu_op_i[g*4 +: 4]))
            ALU_ADD:  w_res = w_a + w_b;
            ALU_SUB:  w_res = w_a - w_b;
            ALU_AND:  w_res = w_a & w_b;
            ALU_OR:   w_res = w_a | w_b;
            ALU_XOR:  w_res = w_a ^ w_b;
            ALU_SLL:  w_res = w_a << w_b[SHAMT_W-1:0];
            ALU_SRL:  w_res = w_a >> w_b[SHAMT_W-1:0];
            ALU_SRA:  w_res = $unsigned($signed(w_a) >>> w_b[SHAMT_W-1:0]);
            ALU_SLT:  w_res = {{(DATA_W-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            ALU_SLTU: w_res = {{(DATA_W-1){1'b0}}, w_a < w_b};
            default:  w_res = '0;
         endcase
      end

      assign alu_ready_o[g] = ~r_valid | alu_ready_i[g];
      assign w_accept       = alu_valid_i[g] & alu_ready_o[g];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_tag   <= '0;
         end else if (w_accept) begin
            r_valid <= 1'b1;
            r_res   <= w_res;
            r_tag   <= alu_tag_i[g*TAG_W +: TAG_W];
         end else if (alu_ready_i[g]) begin
            r_valid <= 1'b0;
         end
      end

      assign alu_valid_o[g]                 = r_valid;
      assign alu_res_o[g*DATA_W +: DATA_W]  = r_res;
      assign alu_tag_o[g*TAG_W +: TAG_W]    = r_tag;
   end

   logic [DATA_W-1:0] w_mulB;

   assign w_mulB = mul_imm_sel_i
                 ? DATA_W'(extendImm(EXT_W'(mul_imm_i), IMM_W, mul_imm_sext_i))
                 : mul_src2_i;

   exec_mul_pipe #(
      .DATA_W  (DATA_W),
      .TAG_W   (TAG_W),
      .MUL_LAT (MUL_LAT)
   ) uMulPipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (mul_valid_i),
      .ready_o (mul_ready_o),
      .a_i     (mul_src1_i),
      .b_i     (w_mulB),
      .tag_i   (mul_tag_i),
      .valid_o (mul_valid_o),
      .ready_i (mul_ready_i),
      .res_o   (mul_res_o),
      .tag_o   (mul_tag_o)
   );

   logic   w_lsAccept;
   logic   w_unusedLs;
   logic   r_lsValid;
   lsReq_t r_lsReq;

   assign w_unusedLs = ^{ls_src2_i[DATA_W-1:ADDR_HI_W], ls_src3_i[DATA_W-1:LS_DATA_W]};
   assign ls_ready_o = ~r_lsValid | ls_ready_i;
   assign w_lsAccept = ls_valid_i & ls_ready_o;

   // An idle request register reads as a load so the memory side never sees a stray write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lsValid <= 1'b0;
         r_lsReq   <= '{addr: '0, data: '0, r_nw: 1'b1, tag: '0};
      end else if (w_lsAccept) begin
         r_lsValid <= 1'b1;
         r_lsReq   <= '{addr: {ls_src2_i[ADDR_HI_W-1:0], ls_src1_i},
                        data: ls_src3_i[LS_DATA_W-1:0],
                        r_nw: ~ls_write_i,
                        tag:  ls_tag_i};
      end else if (ls_ready_i) begin
         r_lsValid <= 1'b0;
      end
   end

   assign ls_valid_o = r_lsValid;
   assign ls_addr_o  = r_lsReq.addr;
   assign ls_data_o  = r_lsReq.data;
   assign ls_r_nw_o  = r_lsReq.r_nw;
   assign ls_tag_o   = r_lsReq.tag;

endmodule

// File: tb/tb_exec_pipe.sv
// Self-checking bench for exec_pipe: directed scenarios followed by random traffic
// scored against an in-order queue model of each lane.
module tb_exec_pipe;
   import exec_pkg::*;

   localparam int DATA_W = 16, TAG_W = 5, IMM_W = 5, NUM_ALU = 2, MUL_LAT = 3;
   localparam int ADDR_HI_W = 9, LS_DATA_W = 8, ADDR_W = DATA_W + ADDR_HI_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NUM_ALU-1:0]        alu_valid_i, alu_ready_o, alu_imm_sel_i, alu_imm_sext_i;
   logic [NUM_ALU-1:0]        alu_valid_o, alu_ready_i;
   logic [NUM_ALU*DATA_W-1:0] alu_src1_i, alu_src2_i, alu_res_o;
   logic [NUM_ALU*IMM_W-1:0]  alu_imm_i;
   logic [NUM_ALU*4-1:0]      alu_op_i;
   logic [NUM_ALU*TAG_W-1:0]  alu_tag_i, alu_tag_o;
   logic                      mul_valid_i, mul_ready_o, mul_imm_sel_i, mul_imm_sext_i;
   logic                      mul_valid_o, mul_ready_i;
   logic [DATA_W-1:0]         mul_src1_i, mul_src2_i, mul_res_o;
   logic [IMM_W-1:0]          mul_imm_i;
   logic [TAG_W-1:0]          mul_tag_i, mul_tag_o;
   logic                      ls_valid_i, ls_ready_o, ls_write_i, ls_valid_o, ls_ready_i, ls_r_nw_o;
   logic [DATA_W-1:0]         ls_src1_i, ls_src2_i, ls_src3_i;
   logic [TAG_W-1:0]          ls_tag_i, ls_tag_o;
   logic [ADDR_W-1:0]         ls_addr_o;
   logic [LS_DATA_W-1:0]      ls_data_o;

   int total = 0;
   int bad   = 0;

   typedef struct { logic [DATA_W-1:0] res; logic [TAG_W-1:0] tag; } resExp_t;
   typedef struct { logic [ADDR_W-1:0] addr; logic [LS_DATA_W-1:0] data; logic rnw; logic [TAG_W-1:0] tag; } lsExp_t;
   resExp_t aluQ [NUM_ALU][$];
   resExp_t mulQ [$];
   lsExp_t  lsQ  [$];

   always #5 clk = ~clk;

   exec_pipe #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .IMM_W(IMM_W), .NUM_ALU(NUM_ALU),
      .MUL_LAT(MUL_LAT), .ADDR_HI_W(ADDR_HI_W), .LS_DATA_W(LS_DATA_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_src1_i(alu_src1_i),
      .alu_src2_i(alu_src2_i), .alu_imm_i(alu_imm_i), .alu_imm_sel_i(alu_imm_sel_i),
      .alu_imm_sext_i(alu_imm_sext_i), .alu_op_i(alu_op_i), .alu_tag_i(alu_tag_i),
      .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_res_o(alu_res_o),
      .alu_tag_o(alu_tag_o),
      .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o), .mul_src1_i(mul_src1_i),
      .mul_src2_i(mul_src2_i), .mul_imm_i(mul_imm_i), .mul_imm_sel_i(mul_imm_sel_i),
      .mul_imm_sext_i(mul_imm_sext_i), .mul_tag_i(mul_tag_i), .mul_valid_o(mul_valid_o),
      .mul_ready_i(mul_ready_i), .mul_res_o(mul_res_o), .mul_tag_o(mul_tag_o),
      .ls_valid_i(ls_valid_i), .ls_ready_o(ls_ready_o), .ls_src1_i(ls_src1_i),
      .ls_src2_i(ls_src2_i), .ls_src3_i(ls_src3_i), .ls_write_i(ls_write_i),
      .ls_tag_i(ls_tag_i), .ls_valid_o(ls_valid_o), .ls_ready_i(ls_ready_i),
      .ls_addr_o(ls_addr_o), .ls_data_o(ls_data_o), .ls_r_nw_o(ls_r_nw_o), .ls_tag_o(ls_tag_o)
   );

   task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Reference arithmetic on plain integers, written from the op definitions.
   function automatic int immValue(input int imm, input bit sext);
      if (sext && imm >= 16) return imm + 65536 - 32;
      return imm;
   endfunction

   function automatic logic [DATA_W-1:0] refAlu(input logic [3:0] op, input int a, input int b);
      int sa, sb, sh;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      sh = b % 16;
      case (op)
         ALU_ADD:  return 16'(a + b);
         ALU_SUB:  return 16'(a - b);
         ALU_AND:  return 16'(a & b);
         ALU_OR:   return 16'(a | b);
         ALU_XOR:  return 16'(a ^ b);
         ALU_SLL:  return 16'(a << sh);
         ALU_SRL:  return 16'(a >> sh);
         ALU_SRA:  return 16'(sa >>> sh);
         ALU_SLT:  return (sa < sb) ? 16'd1 : 16'd0;
         ALU_SLTU: return (a < b) ? 16'd1 : 16'd0;
         default:  return 16'd0;
      endcase
   endfunction

   task automatic setAlu(input int l, input logic [3:0] op, input logic [15:0] s1, input logic [15:0] s2,
                         input logic [4:0] imm, input logic sel, input logic sext, input logic [4:0] tag,
                         input logic vld);
      alu_op_i[l*4 +: 4]          = op;
      alu_src1_i[l*DATA_W +: DATA_W] = s1;
      alu_src2_i[l*DATA_W +: DATA_W] = s2;
      alu_imm_i[l*IMM_W +: IMM_W] = imm;
      alu_imm_sel_i[l]            = sel;
      alu_imm_sext_i[l]           = sext;
      alu_tag_i[l*TAG_W +: TAG_W] = tag;
      alu_valid_i[l]              = vld;
   endtask

   task automatic setMul(input logic [15:0] a, input logic [15:0] b, input logic [4:0] tag, input logic vld);
      mul_src1_i = a; mul_src2_i = b; mul_imm_i = '0; mul_imm_sel_i = 1'b0; mul_imm_sext_i = 1'b0;
      mul_tag_i = tag; mul_valid_i = vld;
   endtask

   task automatic setLs(input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] s3,
                        input logic wr, input logic [4:0] tag, input logic vld);
      ls_src1_i = s1; ls_src2_i = s2; ls_src3_i = s3; ls_write_i = wr; ls_tag_i = tag; ls_valid_i = vld;
   endtask

   task automatic clearInputs();
      for (int l = 0; l < NUM_ALU; l++) setAlu(l, 4'd0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      alu_ready_i = '1;
      setMul(16'd0, 16'd0, 5'd0, 1'b0);
      mul_ready_i = 1'b1;
      setLs(16'd0, 16'd0, 16'd0, 1'b0, 5'd0, 1'b0);
      ls_ready_i = 1'b1;
   endtask

   // One random cycle: drive, then at the falling edge score what the next rising edge will do.
   task automatic applyStimulus(input bit drain);
      resExp_t re;
      lsExp_t  le;
      int a, b;
      bit expRdy;
      for (int l = 0; l < NUM_ALU; l++) begin
         setAlu(l, 4'($urandom), 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom),
                1'($urandom), 5'($urandom), drain ? 1'b0 : 1'($urandom));
         alu_ready_i[l] = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      setMul(16'($urandom), 16'($urandom), 5'($urandom), drain ? 1'b0 : 1'($urandom));
      mul_imm_i = 5'($urandom); mul_imm_sel_i = 1'($urandom); mul_imm_sext_i = 1'($urandom);
      mul_ready_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      setLs(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 5'($urandom),
            drain ? 1'b0 : 1'($urandom));
      ls_ready_i = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      #4;
      for (int l = 0; l < NUM_ALU; l++) begin
         expRdy = (aluQ[l].size() == 0) || alu_ready_i[l];
         checkOutput("rnd_alu_ready", alu_ready_o[l], expRdy);
         checkOutput("rnd_alu_valid", alu_valid_o[l], aluQ[l].size() != 0);
         if (alu_valid_o[l] && alu_ready_i[l] && aluQ[l].size() != 0) begin
            checkOutput("rnd_alu_res", alu_res_o[l*DATA_W +: DATA_W], aluQ[l][0].res);
            checkOutput("rnd_alu_tag", alu_tag_o[l*TAG_W +: TAG_W], aluQ[l][0].tag);
            void'(aluQ[l].pop_front());
         end
         if (alu_valid_i[l] && expRdy) begin
            a = int'(alu_src1_i[l*DATA_W +: DATA_W]);
            b = alu_imm_sel_i[l] ? immValue(int'(alu_imm_i[l*IMM_W +: IMM_W]), alu_imm_sext_i[l])
                                 : int'(alu_src2_i[l*DATA_W +: DATA_W]);
            re.res = refAlu(alu_op_i[l*4 +: 4], a, b);
            re.tag = alu_tag_i[l*TAG_W +: TAG_W];
            aluQ[l].push_back(re);
         end
      end
      checkOutput("rnd_mul_ready", mul_ready_o, !mul_valid_o || mul_ready_i);
      if (mul_valid_o && mul_ready_i) begin
         checkOutput("rnd_mul_nonempty", mulQ.size() != 0, 1);
         if (mulQ.size() != 0) begin
            checkOutput("rnd_mul_res", mul_res_o, mulQ[0].res);
            checkOutput("rnd_mul_tag", mul_tag_o, mulQ[0].tag);
            void'(mulQ.pop_front());
         end
      end
      if (mul_valid_i && mul_ready_o) begin
         b = mul_imm_sel_i ? immValue(int'(mul_imm_i), mul_imm_sext_i) : int'(mul_src2_i);
         re.res = 16'(int'(mul_src1_i) * b);
         re.tag = mul_tag_i;
         mulQ.push_back(re);
      end
      expRdy = (lsQ.size() == 0) || ls_ready_i;
      checkOutput("rnd_ls_ready", ls_ready_o, expRdy);
      checkOutput("rnd_ls_valid", ls_valid_o, lsQ.size() != 0);
      if (ls_valid_o && ls_ready_i && lsQ.size() != 0) begin
         checkOutput("rnd_ls_addr", ls_addr_o, lsQ[0].addr);
         checkOutput("rnd_ls_data", ls_data_o, lsQ[0].data);
         checkOutput("rnd_ls_rnw", ls_r_nw_o, lsQ[0].rnw);
         checkOutput("rnd_ls_tag", ls_tag_o, lsQ[0].tag);
         void'(lsQ.pop_front());
      end
      if (ls_valid_i && expRdy) begin
         le.addr = 25'((int'(ls_src2_i) % 512) * 65536 + int'(ls_src1_i));
         le.data = 8'(int'(ls_src3_i) % 256);
         le.rnw  = !ls_write_i;
         le.tag  = ls_tag_i;
         lsQ.push_back(le);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      clearInputs();
      rst_n = 1'b0;
      repeat (2) stepClock();
      checkOutput("rst_alu_valid", alu_valid_o, 0);
      checkOutput("rst_mul_valid", mul_valid_o, 0);
      checkOutput("rst_ls_valid", ls_valid_o, 0);
      checkOutput("rst_alu_res", alu_res_o, 0);
      checkOutput("rst_ls_addr", ls_addr_o, 0);
      checkOutput("rst_ls_rnw", ls_r_nw_o, 1);
      rst_n = 1'b1;
      stepClock();
      checkOutput("rst_ready_all", {alu_ready_o, mul_ready_o, ls_ready_o}, 4'hF);

      $display("[TB] ALU immediate extension");
      setAlu(0, ALU_ADD, 16'h0005, 16'h0000, 5'h1F, 1'b1, 1'b1, 5'd3, 1'b1);
      stepClock();
      checkOutput("alu_sext_valid", alu_valid_o[0], 1);
      checkOutput("alu_sext_res", alu_res_o[15:0], 16'h0004);
      checkOutput("alu_sext_tag", alu_tag_o[4:0], 5'd3);
      setAlu(0, ALU_ADD, 16'h0005, 16'h0000, 5'h1F, 1'b1, 1'b0, 5'd4, 1'b1);
      stepClock();
      checkOutput("alu_zext_res", alu_res_o[15:0], 16'h0024);
      checkOutput("alu_zext_tag", alu_tag_o[4:0], 5'd4);
      alu_valid_i = '0;
      stepClock();
      checkOutput("alu_idle_valid", alu_valid_o[0], 0);

      $display("[TB] MUL back-to-back latency");
      setMul(16'd3, 16'd4, 5'd1, 1'b1);       stepClock();
      setMul(16'd7, 16'd9, 5'd2, 1'b1);       stepClock();
      checkOutput("mul_early_valid", mul_valid_o, 0);
      setMul(16'hFFFF, 16'd2, 5'd3, 1'b1);    stepClock();
      checkOutput("mul_b2b_res0", {mul_valid_o, mul_tag_o, mul_res_o}, {1'b1, 5'd1, 16'h000C});
      mul_valid_i = 1'b0;                     stepClock();
      checkOutput("mul_b2b_res1", {mul_valid_o, mul_tag_o, mul_res_o}, {1'b1, 5'd2, 16'h003F});
      stepClock();
      checkOutput("mul_b2b_res2", {mul_valid_o, mul_tag_o, mul_res_o}, {1'b1, 5'd3, 16'hFFFE});
      stepClock();
      checkOutput("mul_b2b_empty", mul_valid_o, 0);

      $display("[TB] MUL stall");
      mul_ready_i = 1'b0;
      setMul(16'd5, 16'd6, 5'd8, 1'b1);       stepClock();
      setMul(16'd10, 16'd11, 5'd9, 1'b1);     stepClock();
      mul_valid_i = 1'b0;                     stepClock();
      checkOutput("mul_stall_head", {mul_valid_o, mul_tag_o, mul_res_o}, {1'b1, 5'd8, 16'h001E});
      checkOutput("mul_stall_ready", mul_ready_o, 0);
      setMul(16'd2, 16'd2, 5'd10, 1'b1);
      for (int i = 0; i < 3; i++) begin
         stepClock();
         checkOutput("mul_stall_hold", {mul_valid_o, mul_tag_o, mul_res_o, mul_ready_o},
                     {1'b1, 5'd8, 16'h001E, 1'b0});
      end
      mul_ready_i = 1'b1;
      #1;
      checkOutput("mul_release_ready", mul_ready_o, 1);
      stepClock();
      mul_valid_i = 1'b0;
      checkOutput("mul_release_res1", {mul_valid_o, mul_tag_o, mul_res_o}, {1'b1, 5'd9, 16'h006E});
      stepClock();
      checkOutput("mul_release_bubble", mul_valid_o, 0);
      stepClock();
      checkOutput("mul_release_res2", {mul_valid_o, mul_tag_o, mul_res_o}, {1'b1, 5'd10, 16'h0004});
      stepClock();

      $display("[TB] LS request hold");
      ls_ready_i = 1'b0;
      setLs(16'hBEEF, 16'h01A5, 16'h1234, 1'b1, 5'd7, 1'b1);
      stepClock();
      checkOutput("ls_store_req", {ls_valid_o, ls_addr_o, ls_data_o, ls_r_nw_o, ls_tag_o},
                  {1'b1, 25'h1A5BEEF, 8'h34, 1'b0, 5'd7});
      setLs(16'h1111, 16'h0002, 16'h00AB, 1'b0, 5'd12, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("ls_hold_ready", ls_ready_o, 0);
         stepClock();
         checkOutput("ls_hold_req", {ls_valid_o, ls_addr_o, ls_data_o, ls_r_nw_o, ls_tag_o},
                     {1'b1, 25'h1A5BEEF, 8'h34, 1'b0, 5'd7});
      end
      ls_ready_i = 1'b1;
      stepClock();
      checkOutput("ls_reload_req", {ls_valid_o, ls_addr_o, ls_data_o, ls_r_nw_o, ls_tag_o},
                  {1'b1, 25'h0021111, 8'hAB, 1'b1, 5'd12});
      ls_valid_i = 1'b0;
      stepClock();
      checkOutput("ls_idle_valid", ls_valid_o, 0);

      $display("[TB] ALU1 backpressure");
      alu_ready_i[1] = 1'b0;
      setAlu(1, ALU_SUB, 16'h0010, 16'h0003, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
      stepClock();
      checkOutput("alu1_first", {alu_valid_o[1], alu_tag_o[9:5], alu_res_o[31:16]}, {1'b1, 5'd5, 16'h000D});
      setAlu(1, ALU_XOR, 16'h00F0, 16'h0F0F, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1);
      setAlu(0, ALU_AND, 16'hF0F0, 16'h3C3C, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);
      #1;
      checkOutput("alu1_blocked_ready", alu_ready_o, 2'b01);
      stepClock();
      checkOutput("alu1_held", {alu_valid_o[1], alu_tag_o[9:5], alu_res_o[31:16]}, {1'b1, 5'd5, 16'h000D});
      checkOutput("alu0_free", {alu_valid_o[0], alu_tag_o[4:0], alu_res_o[15:0]}, {1'b1, 5'd1, 16'h3030});
      alu_valid_i[0] = 1'b0;
      alu_ready_i[1] = 1'b1;
      stepClock();
      checkOutput("alu1_reload", {alu_valid_o[1], alu_tag_o[9:5], alu_res_o[31:16]}, {1'b1, 5'd6, 16'h0FFF});
      checkOutput("alu0_drained", alu_valid_o[0], 0);
      clearInputs();
      stepClock();

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) applyStimulus(1'b0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1);
      checkOutput("rnd_drain_empty", aluQ[0].size() + aluQ[1].size() + mulQ.size() + lsQ.size(), 0);

      $display("[TB] reset while busy");
      clearInputs();
      alu_ready_i = '0; mul_ready_i = 1'b0; ls_ready_i = 1'b0;
      setAlu(0, ALU_OR, 16'h1200, 16'h0034, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
      setAlu(1, ALU_ADD, 16'h0001, 16'h0001, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
      setMul(16'd9, 16'd9, 5'd4, 1'b1);
      setLs(16'h4321, 16'h0001, 16'h0055, 1'b1, 5'd5, 1'b1);
      repeat (3) stepClock();
      checkOutput("busy_valids", {alu_valid_o, mul_valid_o, ls_valid_o}, 4'hF);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valids", {alu_valid_o, mul_valid_o, ls_valid_o}, 4'h0);
      checkOutput("midrst_alu", {alu_res_o, alu_tag_o}, 0);
      checkOutput("midrst_mul", {mul_res_o, mul_tag_o}, 0);
      checkOutput("midrst_ls", {ls_addr_o, ls_data_o, ls_tag_o}, 0);
      checkOutput("midrst_rnw", ls_r_nw_o, 1);
      clearInputs();
      stepClock();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         stepClock();
         checkOutput("postrst_no_pulse", {alu_valid_o, mul_valid_o, ls_valid_o}, 4'h0);
      end
      checkOutput("postrst_ready", {alu_ready_o, mul_ready_o, ls_ready_o}, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
